reset_phase_gen: RTL

Downstream consumer of the bench clock/reset source in the MCS8 pipeline bench. It takes the raw clock and the raw asynchronous active-low reset, synchronizes reset release, and stretches it by a fixed hold count. Once released, it generates the two-phase enable strobes (PHI1/PHI2) and the SYNC machine-cycle marker that drive the pipeline stages. Every pipeline stage resets from `nRST_O` rather than from the raw reset.

---
 rtl/reset_phase_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/reset_phase_gen.sv
// Reset-release synchronizer and stretcher feeding a 4-clock PHI1/PHI2/SYNC phase generator.
// Outputs are registered; STALL_I freezes the phase only once the pipeline reset has been released.
module reset_phase_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic       CLK_I,
    input  logic       nRST_I,
    input  logic       STALL_I,
    output logic       nRST_O,
    output logic       PHI1_O,
    output logic       PHI2_O,
    output logic       SYNC_O,
    output logic [1:0] PHASE_O
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   nrst_q, nrst_d;
    logic                   phi1_q, phi1_d;
    logic                   phi2_q, phi2_d;
    logic                   sync_q, sync_d;
    logic [1:0]             phase_q, phase_d;
    logic [1:0]             phase_nxt;
    logic                   rst_sync;

    assign rst_sync  = sync_chain_q[SYNC_STAGES-1];
    assign phase_nxt = phase_q + 2'd1;

    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], 1'b1};
        state_d      = state_q;
        cnt_d        = cnt_q;
        nrst_d       = nrst_q;
        phi1_d       = phi1_q;
        phi2_d       = phi2_q;
        sync_d       = sync_q;
        phase_d      = phase_q;
        case (state_q)
            ST_RESET: begin
                if (rst_sync) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    // Release edge: first PHI1 coincides with nRST_O rising.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    nrst_d  = 1'b1;
                    phase_d = 2'd0;
                    phi1_d  = 1'b1;
                    phi2_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (STALL_I) begin
                    phi1_d = 1'b0;
                    phi2_d = 1'b0;
                end else begin
                    phase_d = phase_nxt;
                    phi1_d  = (phase_nxt == 2'd0);
                    phi2_d  = (phase_nxt == 2'd2);
                    if (phase_q == 2'd3) begin
                        sync_d = ~sync_q;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q      <= ST_RESET;
            sync_chain_q <= '0;
            cnt_q        <= '0;
            nrst_q       <= 1'b0;
            phi1_q       <= 1'b0;
            phi2_q       <= 1'b0;
            sync_q       <= 1'b0;
            phase_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            sync_chain_q <= sync_chain_d;
            cnt_q        <= cnt_d;
            nrst_q       <= nrst_d;
            phi1_q       <= phi1_d;
            phi2_q       <= phi2_d;
            sync_q       <= sync_d;
            phase_q      <= phase_d;
        end
    end

    assign nRST_O  = nrst_q;
    assign PHI1_O  = phi1_q;
    assign PHI2_O  = phi2_q;
    assign SYNC_O  = sync_q;
    assign PHASE_O = phase_q;

endmodule
